// File: rtl/ball_brick_scheduler.sv
// Ball-vs-brick collision sequencer: probes the bricks just beyond the ball's
// leading edges, decrements live ones and shares the brick memory port with the draw engine.
module ball_brick_scheduler #(
   parameter int BRICK_W = 32,
   parameter int BRICK_H = 16,
   parameter int GRID_W  = 640,
   parameter int GRID_H  = 240
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       logic_go,
   input  logic [9:0] ballx,
   input  logic [9:0] bally,
   input  logic [9:0] size,
   input  logic       x_du,
   input  logic       y_du,
   input  logic       draw_req,
   input  logic [9:0] draw_x,
   input  logic [9:0] draw_y,
   input  logic       draw_rd,
   output logic       draw_gnt,
   output logic [9:0] mem_x,
   output logic [9:0] mem_y,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [1:0] mem_wdata,
   input  logic [1:0] mem_rdata,
   output logic       busy,
   output logic       done,
   output logic       x_flip,
   output logic       y_flip,
   output logic [2:0] hits,
   output logic       overrun
);
   localparam int LOG_W = $clog2(BRICK_W);
   localparam int LOG_H = $clog2(BRICK_H);

   typedef enum logic [2:0] {IDLE, LATCH, RD, WT, EV, DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_gnt, r_pend, r_overrun;
   logic [9:0]  r_bx, r_by, r_sz;
   logic        r_xdu, r_ydu;
   logic [3:0]  r_rem;
   logic [1:0]  r_cur;
   logic [1:0]  r_health;
   logic        r_xf, r_yf;
   logic [2:0]  r_hits;

   logic        w_go_ok, w_drop, w_start;
   logic [10:0] w_bx_ext, w_by_ext, w_bx_end, w_by_end, w_bx_last, w_by_last;
   logic [10:0] w_px, w_py;
   logic        w_v_act, w_h_act;
   logic [10:0] w_px_arr [4];
   logic [10:0] w_py_arr [4];
   logic [3:0]  w_pv, w_mask;
   logic [1:0]  w_sel;

   function automatic logic [1:0] lowest(input logic [3:0] m);
      lowest = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (m[i]) lowest = 2'(i);
   endfunction

   assign w_go_ok = logic_go && (r_state == IDLE) && !r_pend;
   assign w_drop  = logic_go && !w_go_ok;
   assign w_start = (r_state == IDLE) && (r_pend || logic_go) && !(r_gnt && draw_req);

   // Probe slots 0/1 are V1/V2, slots 2/3 are H1/H2; all derived from the captured ball.
   always_comb begin
      w_bx_ext  = {1'b0, r_bx};
      w_by_ext  = {1'b0, r_by};
      w_bx_end  = w_bx_ext + {1'b0, r_sz};
      w_by_end  = w_by_ext + {1'b0, r_sz};
      w_bx_last = w_bx_end - 11'd1;
      w_by_last = w_by_end - 11'd1;
      w_v_act   = r_ydu ? (w_by_end[LOG_H-1:0] == '0)
                        : ((r_by[LOG_H-1:0] == '0) && (r_by != '0));
      w_h_act   = r_xdu ? (w_bx_end[LOG_W-1:0] == '0)
                        : ((r_bx[LOG_W-1:0] == '0) && (r_bx != '0));
      w_py      = r_ydu ? w_by_end : (w_by_ext - 11'd1);
      w_px      = r_xdu ? w_bx_end : (w_bx_ext - 11'd1);
      w_px_arr[0] = w_bx_ext;   w_py_arr[0] = w_py;
      w_px_arr[1] = w_bx_last;  w_py_arr[1] = w_py;
      w_px_arr[2] = w_px;       w_py_arr[2] = w_by_ext;
      w_px_arr[3] = w_px;       w_py_arr[3] = w_by_last;
      w_pv[0] = w_v_act;
      w_pv[1] = w_v_act && (w_bx_last[10:LOG_W] != w_bx_ext[10:LOG_W]);
      w_pv[2] = w_h_act;
      w_pv[3] = w_h_act && (w_by_last[10:LOG_H] != w_by_ext[10:LOG_H]);
      for (int i = 0; i < 4; i++)
         if ((w_px_arr[i] >= 11'(GRID_W)) || (w_py_arr[i] >= 11'(GRID_H)))
            w_pv[i] = 1'b0;
      w_mask = (r_state == LATCH) ? w_pv : r_rem;
      w_sel  = lowest(w_mask);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      mem_x       = '0;
      mem_y       = '0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_wdata   = '0;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = LATCH;
         LATCH:   w_state_nxt = (w_pv == '0) ? DONE : RD;
         RD:      w_state_nxt = WT;
         WT:      w_state_nxt = EV;
         EV:      w_state_nxt = (r_rem == '0) ? DONE : RD;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (r_gnt) begin
         mem_x  = draw_x;
         mem_y  = draw_y;
         mem_rd = draw_rd;
      end else if (r_state == RD || r_state == WT || r_state == EV) begin
         mem_x  = w_px_arr[r_cur][9:0];
         mem_y  = w_py_arr[r_cur][9:0];
         mem_rd = (r_state == RD);
         if (r_state == EV && r_health != 2'd0) begin
            mem_wr    = 1'b1;
            mem_wdata = r_health - 2'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_gnt     <= 1'b0;
         r_pend    <= 1'b0;
         r_overrun <= 1'b0;
         r_bx      <= '0;
         r_by      <= '0;
         r_sz      <= '0;
         r_xdu     <= 1'b0;
         r_ydu     <= 1'b0;
         r_rem     <= '0;
         r_cur     <= '0;
         r_health  <= '0;
         r_xf      <= 1'b0;
         r_yf      <= 1'b0;
         r_hits    <= '0;
      end else begin
         r_overrun <= w_drop;
         r_gnt     <= (r_state == IDLE) && !w_start && draw_req;
         if (w_start)
            r_pend <= 1'b0;
         else if (w_go_ok && r_gnt && draw_req)
            r_pend <= 1'b1;
         if (w_go_ok) begin
            r_bx  <= ballx;
            r_by  <= bally;
            r_sz  <= size;
            r_xdu <= x_du;
            r_ydu <= y_du;
         end
         if (r_state == LATCH) begin
            r_xf   <= 1'b0;
            r_yf   <= 1'b0;
            r_hits <= '0;
         end
         if (r_state == WT)
            r_health <= mem_rdata;
         if (r_state == EV && r_health != 2'd0) begin
            r_hits <= r_hits + 3'd1;
            if (r_cur[1]) r_xf <= 1'b1;
            else          r_yf <= 1'b1;
         end
         // Advance to the next pending probe slot when leaving LATCH or EV.
         if (r_state == LATCH || r_state == EV) begin
            r_cur <= w_sel;
            r_rem <= w_mask & ~(4'b0001 << w_sel);
         end
      end
   end

   assign draw_gnt = r_gnt;
   assign busy     = r_pend || (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign x_flip   = done && r_xf;
   assign y_flip   = done && r_yf;
   assign hits     = done ? r_hits : 3'd0;
   assign overrun  = r_overrun;

endmodule
